// File: rtl/fixed_to_ieee754.sv
// fixed_to_ieee754: iterative signed fixed-point to IEEE-754 single converter.
// Normalizes one bit per cycle, rounds to nearest-even, valid/ready on both sides.
`default_nettype none

module fixed_to_ieee754 #(
   parameter int INT_BITS  = 22,
   parameter int FRAC_BITS = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [INT_BITS+FRAC_BITS-1:0] in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [31:0]                   out_data,
   output logic                          out_valid,
   input  logic                          out_ready
);

   localparam int W = INT_BITS + FRAC_BITS;
   // Biased exponent of the MSB position; the legal parameter range keeps
   // every reachable exponent within 1..254, so 8 bits hold it exactly.
   localparam logic [7:0] C_EXP_INIT = 8'((W - 1) - FRAC_BITS + 127);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_NORM  = 2'd1,
      S_ROUND = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t         r_state;
   logic           r_sign;
   logic [W-1:0]   r_mag;
   logic [7:0]     r_exp;

   logic [W-1:0]   w_mag;
   logic [22:0]    w_m;
   logic           w_g;
   logic           w_s;
   logic           w_rnd;
   logic [23:0]    w_m_inc;

   // Two's complement negate; -2^(W-1) maps onto itself, which is the correct magnitude.
   assign w_mag = in_data[W-1] ? ((~in_data) + {{(W-1){1'b0}}, 1'b1}) : in_data;

   assign w_m = r_mag[W-2:W-24];
   assign w_g = r_mag[W-25];

   generate
      if (W > 25) begin : g_sticky
         assign w_s = |r_mag[W-26:0];
      end else begin : g_no_sticky
         assign w_s = 1'b0;
      end
   endgenerate

   assign w_rnd   = w_g & (w_s | w_m[0]);
   assign w_m_inc = {1'b0, w_m} + {23'd0, w_rnd};

   assign in_ready = (r_state == S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_sign    <= 1'b0;
         r_mag     <= '0;
         r_exp     <= 8'd0;
         out_data  <= 32'd0;
         out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_sign <= in_data[W-1];
                  r_mag  <= w_mag;
                  r_exp  <= C_EXP_INIT;
                  if (in_data == '0) begin
                     out_data  <= 32'd0;
                     out_valid <= 1'b1;
                     r_state   <= S_DONE;
                  end else begin
                     r_state <= S_NORM;
                  end
               end
            end
            S_NORM: begin
               if (r_mag[W-1]) begin
                  r_state <= S_ROUND;
               end else begin
                  r_mag <= r_mag << 1;
                  r_exp <= r_exp - 8'd1;
               end
            end
            S_ROUND: begin
               // Mantissa overflow from rounding lands exactly on the next power of two.
               if (w_m_inc[23]) begin
                  out_data <= {r_sign, r_exp + 8'd1, 23'd0};
               end else begin
                  out_data <= {r_sign, r_exp, w_m_inc[22:0]};
               end
               out_valid <= 1'b1;
               r_state   <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fixed_to_ieee754.sv
// tb_fixed_to_ieee754: directed vector table plus backpressure and reset sequences.
`default_nettype none

module tb_fixed_to_ieee754;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [37:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   fixed_to_ieee754 #(.INT_BITS(22), .FRAC_BITS(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [37:0] din;
      logic [31:0] dout;
      int          lat;   // edges from the capture edge to out_valid visible
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h required %0h", nm, act, req);
      end
   endtask

   task automatic wait_valid(output int n, output bit seen);
      n = 0;
      seen = out_valid;
      while (!seen && n < 100) begin
         @(posedge clk); #1;
         n++;
         seen = out_valid;
      end
   endtask

   task automatic run_vec(input vec_t v);
      int n;
      bit seen;
      @(negedge clk);
      chk({v.name, " idle"}, {63'd0, in_ready}, 64'd1);
      in_data  = v.din;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_valid(n, seen);
      chk({v.name, " valid"}, {63'd0, seen}, 64'd1);
      chk({v.name, " latency"}, 64'(n), 64'(v.lat));
      chk({v.name, " data"}, {32'd0, out_data}, {32'd0, v.dout});
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({v.name, " release"}, {62'd0, in_ready, out_valid}, 64'd2);
   endtask

   vec_t vecs[10];

   initial begin
      int  n;
      bit  seen;
      bit  stray;

      vecs[0] = '{"one",        38'h0000010000, 32'h3F800000, 23};
      vecs[1] = '{"neg1p5",     38'h3FFFFE8000, 32'hBFC00000, 23};
      vecs[2] = '{"minneg",     38'h2000000000, 32'hCA000000, 2};
      vecs[3] = '{"maxpos",     38'h1FFFFFFFFF, 32'h4A000000, 3};
      vecs[4] = '{"tie_even",   38'h0001000001, 32'h43800000, 15};
      vecs[5] = '{"tie_odd",    38'h0001000003, 32'h43800002, 15};
      vecs[6] = '{"zero",       38'h0000000000, 32'h00000000, 0};
      vecs[7] = '{"half",       38'h0000008000, 32'h3F000000, 24};
      vecs[8] = '{"neg_one",    38'h3FFFFF0000, 32'hBF800000, 23};
      vecs[9] = '{"lsb_only",   38'h0000000001, 32'h37800000, 39};

      #2;
      chk("reset in_ready", {63'd0, in_ready}, 64'd1);
      chk("reset out_valid", {63'd0, out_valid}, 64'd0);
      chk("reset out_data", {32'd0, out_data}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) run_vec(vecs[i]);

      // Backpressure: result held while a new sample waits upstream.
      @(negedge clk);
      in_data  = 38'h0000010000;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_valid(n, seen);
      chk("bp first valid", {63'd0, seen}, 64'd1);
      @(negedge clk);
      in_data  = 38'h3FFFFE8000;
      in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         chk("bp in_ready", {63'd0, in_ready}, 64'd0);
         chk("bp out_valid", {63'd0, out_valid}, 64'd1);
         chk("bp out_data", {32'd0, out_data}, 64'h3F800000);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp back to idle", {62'd0, in_ready, out_valid}, 64'd2);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp second capture", {63'd0, in_ready}, 64'd0);
      wait_valid(n, seen);
      chk("bp second valid", {63'd0, seen}, 64'd1);
      chk("bp second latency", 64'(n), 64'd23);
      chk("bp second data", {32'd0, out_data}, 64'hBFC00000);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Reset in the middle of normalization.
      @(negedge clk);
      in_data  = 38'h0000000001;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst out_data", {32'd0, out_data}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      stray = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(posedge clk); #1;
         if (out_valid) stray = 1'b1;
      end
      chk("rst no stale valid", {63'd0, stray}, 64'd0);
      run_vec(vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
